// File: rtl/pipe_stage_buf.sv
// Elastic DEPTH-entry in-order pipeline stage with ready_go hold and whole-stage flush.
// Optional same-cycle bypass when empty is enabled by defining PIPE_STAGE_BYPASS_EN.
module pipe_stage_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prev_validto,
  input  logic [WIDTH-1:0] data_in,
  output logic             allowin,
  input  logic             ready_go,
  input  logic             flush,
  input  logic             next_allowin,
  output logic             validto,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             head_valid;
  logic             push_st;
  logic             pop_st;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign head_valid = !empty & ready_go & !flush;
  // Stored-entry pop only, so allowin never sees prev_validto through the bypass path.
  assign pop_st     = head_valid & next_allowin;
  assign allowin    = !full | pop_st;

`ifdef PIPE_STAGE_BYPASS_EN
  logic bypass;
  assign bypass   = empty & prev_validto & ready_go & next_allowin & !flush;
  assign validto  = head_valid | bypass;
  assign data_out = bypass ? data_in : mem[rd_ptr];
  assign push_st  = prev_validto & allowin & !flush & !bypass;
`else
  assign validto  = head_valid;
  assign data_out = mem[rd_ptr];
  assign push_st  = prev_validto & allowin & !flush;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_st) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop_st) rd_ptr <= next_ptr(rd_ptr);
      case ({push_st, pop_st})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf (DEPTH=3, WIDTH=32); follows PIPE_STAGE_BYPASS_EN if defined.
module tb_pipe_stage_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             prev_validto = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             allowin;
  logic             ready_go = 1'b1;
  logic             flush = 1'b0;
  logic             next_allowin = 1'b0;
  logic             validto;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;

  int n_total = 0;
  int n_pass  = 0;
  logic [WIDTH-1:0] sb[$];

  pipe_stage_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .prev_validto(prev_validto), .data_in(data_in),
    .allowin(allowin), .ready_go(ready_go), .flush(flush),
    .next_allowin(next_allowin), .validto(validto), .data_out(data_out),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every downstream transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && validto && next_allowin) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pop: got %h expected no transfer", data_out);
      end else begin
        check("pop_data", data_out, sb.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_validto", 32'(validto), 0);
    check("rst_allowin", 32'(allowin), 1);
    check("rst_data_out", data_out, 0);
    step();
    rst = 1'b0;
    step();

    // Reset mid-stream with two entries held.
    prev_validto = 1'b1; data_in = 32'h11; sb.push_back(32'h11); step();
    data_in = 32'h22; sb.push_back(32'h22); step();
    prev_validto = 1'b0;
    check("midrst_pre_count", 32'(count), 2);
    rst = 1'b1; #1;
    sb.delete();
    check("midrst_count", 32'(count), 0);
    check("midrst_validto", 32'(validto), 0);
    check("midrst_allowin", 32'(allowin), 1);
    check("midrst_data_out", data_out, 0);
    step();
    rst = 1'b0;
    step();

    // Fill to full with downstream stalled; D waits until A pops.
    prev_validto = 1'b1;
    data_in = 32'hA; sb.push_back(32'hA); step();
    data_in = 32'hB; sb.push_back(32'hB); step();
    data_in = 32'hC; sb.push_back(32'hC); step();
    data_in = 32'hD;
    check("fill_full", 32'(full), 1);
    check("fill_allowin", 32'(allowin), 0);
    next_allowin = 1'b1; #1;
    check("fill_allowin_on_pop", 32'(allowin), 1);
    sb.push_back(32'hD);
    step();
    prev_validto = 1'b0;
    check("fill_count_swap", 32'(count), 3);
    step(); step(); step();
    check("fill_drained", 32'(empty), 1);

    // Stream 0x1..0xA through a full buffer; pointers wrap repeatedly.
    next_allowin = 1'b0;
    prev_validto = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data_in = 32'(i); sb.push_back(32'(i)); step();
    end
    check("stream_full", 32'(full), 1);
    next_allowin = 1'b1;
    for (int i = 4; i <= 10; i++) begin
      data_in = 32'(i); sb.push_back(32'(i)); step();
      check("stream_count", 32'(count), 3);
    end
    prev_validto = 1'b0;
    step(); step(); step();
    check("stream_drained", 32'(empty), 1);

    // ready_go low holds a single entry.
    ready_go = 1'b0;
    prev_validto = 1'b1; data_in = 32'h55; sb.push_back(32'h55); step();
    prev_validto = 1'b0;
    check("hold_validto", 32'(validto), 0);
    step(); step();
    check("hold_count", 32'(count), 1);
    ready_go = 1'b1; #1;
    check("hold_release_validto", 32'(validto), 1);
    step();
    check("hold_popped", 32'(count), 0);

    // Flush with two entries and an incoming payload.
    next_allowin = 1'b0;
    prev_validto = 1'b1;
    data_in = 32'h61; sb.push_back(32'h61); step();
    data_in = 32'h62; sb.push_back(32'h62); step();
    data_in = 32'h63; flush = 1'b1; #1;
    sb.delete();
    check("flush_validto", 32'(validto), 0);
    check("flush_allowin", 32'(allowin), 1);
    step();
    flush = 1'b0; prev_validto = 1'b0;
    check("flush_count", 32'(count), 0);
    next_allowin = 1'b1;
    step();
    check("flush_nothing_offered", 32'(validto), 0);

    // Empty buffer, downstream ready: bypass or one-cycle latency.
    prev_validto = 1'b1; data_in = 32'hDEAD_BEEF; sb.push_back(32'hDEAD_BEEF); #1;
`ifdef PIPE_STAGE_BYPASS_EN
    check("bypass_validto", 32'(validto), 1);
    check("bypass_data_out", data_out, 32'hDEAD_BEEF);
    check("bypass_count", 32'(count), 0);
    step();
    prev_validto = 1'b0;
    check("bypass_after_count", 32'(count), 0);
`else
    check("lat_validto_same_cycle", 32'(validto), 0);
    step();
    prev_validto = 1'b0;
    check("lat_validto_next", 32'(validto), 1);
    check("lat_data_out", data_out, 32'hDEAD_BEEF);
    check("lat_count", 32'(count), 1);
    step();
    check("lat_after_count", 32'(count), 0);
`endif
    step();
    check("sb_empty_at_end", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
